// File: rtl/text_pkg.sv
// Shared constants, control codes and controller state encoding for the text screen buffer.
package text_pkg;

  localparam int CHAR_W = 8;

  localparam int DEF_ROWS       = 7;
  localparam int DEF_COLS       = 20;
  localparam int DEF_NUM_GLYPHS = 130;
  localparam int DEF_BLINK_DIV  = 25000000;

  localparam logic [CHAR_W-1:0] DEF_BLANK_CHAR = 8'h20;
  localparam logic [CHAR_W-1:0] SUBST_CHAR     = 8'h3F;
  localparam logic [CHAR_W-1:0] CURSOR_CHAR    = 8'h5F;

  localparam logic [CHAR_W-1:0] CC_BS = 8'h08;
  localparam logic [CHAR_W-1:0] CC_LF = 8'h0A;
  localparam logic [CHAR_W-1:0] CC_FF = 8'h0C;
  localparam logic [CHAR_W-1:0] CC_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SCROLL = 2'd2
  } state_t;

endpackage

// File: rtl/text_cell_ram.sv
// Glyph cell store: one synchronous write port, async display and scroll-source read ports.
// Reads return the pre-edge contents; out-of-array addresses read as zero.
module text_cell_ram
  import text_pkg::*;
#(
  parameter int DEPTH = DEF_ROWS * DEF_COLS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [CHAR_W-1:0] wdata,
  input  logic [AW-1:0]     disp_addr,
  output logic [CHAR_W-1:0] disp_data,
  input  logic [AW-1:0]     src_addr,
  output logic [CHAR_W-1:0] src_data
);

  logic [CHAR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign disp_data = (int'(disp_addr) < DEPTH) ? mem[disp_addr] : '0;
  assign src_data  = (int'(src_addr) < DEPTH) ? mem[src_addr] : '0;

endmodule

// File: rtl/text_screen_buffer.sv
// Text cell grid with write cursor; bytes accepted only in IDLE, written cell readable one cycle later.
// CLEAR and SCROLL walk one cell per cycle with char_ready low; optional CURSOR_BLINK_EN overlays '_' at the cursor.
module text_screen_buffer
  import text_pkg::*;
#(
  parameter int          ROWS       = DEF_ROWS,
  parameter int          COLS       = DEF_COLS,
  parameter int          NUM_GLYPHS = DEF_NUM_GLYPHS,
  parameter logic [7:0]  BLANK_CHAR = DEF_BLANK_CHAR
`ifdef CURSOR_BLINK_EN
  , parameter int        BLINK_DIV  = DEF_BLINK_DIV
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [3:0] rin,
  input  logic [5:0] cin,
  output logic [7:0] charout,
  output logic [3:0] cursor_row,
  output logic [5:0] cursor_col,
  output logic       busy
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = $clog2(CELLS);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CELLS - 1);
  localparam logic [IDX_W-1:0] SHIFT_END  = IDX_W'((ROWS - 1) * COLS);
  localparam logic [IDX_W-1:0] ROW_STRIDE = IDX_W'(COLS);
  localparam logic [3:0]       LAST_ROW   = 4'(ROWS - 1);
  localparam logic [5:0]       LAST_COL   = 6'(COLS - 1);

  function automatic logic [IDX_W-1:0] cell_addr(input logic [3:0] r, input logic [5:0] c);
    return IDX_W'(r) * ROW_STRIDE + IDX_W'(c);
  endfunction

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [3:0]       row, row_n;
  logic [5:0]       col, col_n;

  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [7:0]       wdata;
  logic [7:0]       disp_data;
  logic [7:0]       src_data;
  logic [7:0]       stored;
  logic             in_range;
  logic             accept;

  assign accept     = char_valid && (state == IDLE);
  assign char_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign cursor_row = row;
  assign cursor_col = col;

  text_cell_ram #(
    .DEPTH (CELLS),
    .AW    (IDX_W)
  ) u_ram (
    .clk       (clk),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .disp_addr (cell_addr(rin, cin)),
    .disp_data (disp_data),
    .src_addr  (idx + ROW_STRIDE),
    .src_data  (src_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      idx   <= '0;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      row   <= row_n;
      col   <= col_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    row_n   = row;
    col_n   = col;
    we      = 1'b0;
    waddr   = idx;
    wdata   = BLANK_CHAR;
    case (state)
      CLEAR: begin
        we = 1'b1;
        if (idx == LAST_IDX) begin
          state_n = IDLE;
          idx_n   = '0;
          row_n   = '0;
          col_n   = '0;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      SCROLL: begin
        // Rows 0..ROWS-2 copy from the row below; the last row is blanked.
        we    = 1'b1;
        wdata = (idx < SHIFT_END) ? src_data : BLANK_CHAR;
        if (idx == LAST_IDX) begin
          state_n = IDLE;
          idx_n   = '0;
          row_n   = LAST_ROW;
          col_n   = '0;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      IDLE: begin
        if (accept) begin
          case (char_in)
            CC_FF: begin
              state_n = CLEAR;
              idx_n   = '0;
            end
            CC_LF, CC_CR: begin
              col_n = '0;
              if (row < LAST_ROW) begin
                row_n = row + 4'd1;
              end else begin
                state_n = SCROLL;
                idx_n   = '0;
              end
            end
            CC_BS: begin
              if (col != 6'd0) begin
                col_n = col - 6'd1;
                we    = 1'b1;
                waddr = cell_addr(row, col - 6'd1);
              end else if (row != 4'd0) begin
                row_n = row - 4'd1;
                col_n = LAST_COL;
                we    = 1'b1;
                waddr = cell_addr(row - 4'd1, LAST_COL);
              end
            end
            default: begin
              we    = 1'b1;
              waddr = cell_addr(row, col);
              wdata = (int'(char_in) < NUM_GLYPHS) ? char_in : SUBST_CHAR;
              if (col < LAST_COL) begin
                col_n = col + 6'd1;
              end else begin
                col_n = '0;
                if (row < LAST_ROW) begin
                  row_n = row + 4'd1;
                end else begin
                  state_n = SCROLL;
                  idx_n   = '0;
                end
              end
            end
          endcase
        end
      end
      default: begin
        state_n = CLEAR;
        idx_n   = '0;
      end
    endcase
  end

  assign in_range = (rin <= LAST_ROW) && (cin <= LAST_COL);
  assign stored   = in_range ? disp_data : BLANK_CHAR;

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign charout = ((state == IDLE) && blink_phase && (rin == row) && (cin == col)) ?
                   CURSOR_CHAR : stored;
`else
  assign charout = stored;
`endif

endmodule

// File: tb/tb_text_screen_buffer.sv
// Randomized bench for text_screen_buffer against a grid-level reference model.
module tb_text_screen_buffer;

    localparam int ROWS  = 7;
    localparam int COLS  = 20;
    localparam int CELLS = ROWS * COLS;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [3:0] rin;
    logic [5:0] cin;
    logic [7:0] charout;
    logic [3:0] cursor_row;
    logic [5:0] cursor_col;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

`ifdef CURSOR_BLINK_EN
    text_screen_buffer #(.BLINK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .rin        (rin),
        .cin        (cin),
        .charout    (charout),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );
`else
    text_screen_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .rin        (rin),
        .cin        (cin),
        .charout    (charout),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );
`endif

    logic [7:0] m_cell [ROWS][COLS];
    int m_row, m_col;

    function automatic logic [7:0] exp_read(input int r, input int c);
        if (r >= ROWS || c >= COLS) return 8'h20;
`ifdef CURSOR_BLINK_EN
        if (r == m_row && c == m_col && ((cyc / 4) % 2) == 1) return 8'h5F;
`endif
        return m_cell[r][c];
    endfunction

    task automatic model_blank();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_cell[r][c] = 8'h20;
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_scroll();
        for (int r = 0; r < ROWS - 1; r++) m_cell[r] = m_cell[r + 1];
        for (int c = 0; c < COLS; c++) m_cell[ROWS - 1][c] = 8'h20;
        m_row = ROWS - 1;
        m_col = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit busy_exp);
        busy_exp = 0;
        case (b)
            8'h0C: begin model_blank(); busy_exp = 1; end
            8'h0A, 8'h0D: begin
                m_col = 0;
                if (m_row < ROWS - 1) m_row++;
                else begin model_scroll(); busy_exp = 1; end
            end
            8'h08: begin
                if (m_col > 0) begin m_col--; m_cell[m_row][m_col] = 8'h20; end
                else if (m_row > 0) begin m_row--; m_col = COLS - 1; m_cell[m_row][m_col] = 8'h20; end
            end
            default: begin
                m_cell[m_row][m_col] = (b < 8'd130) ? b : 8'h3F;
                if (m_col < COLS - 1) m_col++;
                else begin
                    m_col = 0;
                    if (m_row < ROWS - 1) m_row++;
                    else begin model_scroll(); busy_exp = 1; end
                end
            end
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard, nbusy, tr, tc;
        bit busy_exp, rdy_bad, printable;
        printable = !(b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D);
        @(negedge clk);
        char_in = b;
        char_valid = 1'b1;
        guard = 0;
        while (char_ready !== 1'b1 && guard < 400) begin @(negedge clk); guard++; end
        if (char_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL send_ready_timeout got=%b exp=1", char_ready);
            char_valid = 1'b0;
            return;
        end
        tr = m_row; tc = m_col;
        if (printable) begin
            rin = 4'(tr); cin = 6'(tc); #1;
            checks++;
            if (charout !== exp_read(tr, tc)) begin
                failures++;
                $display("FAIL pre_write_old_value got=%h exp=%h", charout, exp_read(tr, tc));
            end
        end
        @(posedge clk); #1;
        model_byte(b, busy_exp);
        char_in = 8'($urandom);
        char_valid = busy_exp;
        if (busy_exp) begin
            nbusy = 0; rdy_bad = 0;
            @(negedge clk);
            while (busy === 1'b1 && nbusy < 400) begin
                if (char_ready !== 1'b0) rdy_bad = 1;
                nbusy++;
                @(negedge clk);
            end
            char_valid = 1'b0;
            checks++;
            if (nbusy != CELLS) begin
                failures++;
                $display("FAIL busy_cycles got=%0d exp=%0d", nbusy, CELLS);
            end
            checks++;
            if (rdy_bad) begin
                failures++;
                $display("FAIL ready_while_busy got=1 exp=0");
            end
        end else if (printable) begin
            rin = 4'(tr); cin = 6'(tc); #1;
            checks++;
            if (charout !== exp_read(tr, tc)) begin
                failures++;
                $display("FAIL write_latency got=%h exp=%h", charout, exp_read(tr, tc));
            end
        end
        checks++;
        if (cursor_row !== 4'(m_row) || cursor_col !== 6'(m_col)) begin
            failures++;
            $display("FAIL cursor byte=%h got=(%0d,%0d) exp=(%0d,%0d)", b, cursor_row, cursor_col, m_row, m_col);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; char_valid = 1'b1; char_in = 8'h5A; rin = '0; cin = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (char_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_flags got=ready%b/busy%b exp=ready0/busy1", char_ready, busy);
        end
        checks++;
        if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin
            failures++;
            $display("FAIL reset_cursor got=(%0d,%0d) exp=(0,0)", cursor_row, cursor_col);
        end
        reset = 1'b0;
        model_blank();
        n = 0;
        while (char_ready !== 1'b1 && n < 400) begin n++; @(negedge clk); end
        char_valid = 1'b0;
        checks++;
        if (n != CELLS) begin
            failures++;
            $display("FAIL reset_clear_cycles got=%0d exp=%0d", n, CELLS);
        end
        checks++;
        if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin
            failures++;
            $display("FAIL clear_cursor got=(%0d,%0d) exp=(0,0)", cursor_row, cursor_col);
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                @(negedge clk); rin = 4'(r); cin = 6'(c); #1;
                checks++;
                if (charout !== exp_read(r, c)) begin
                    failures++;
                    $display("FAIL reset_screen r=%0d c=%0d got=%h exp=%h", r, c, charout, exp_read(r, c));
                end
            end
    endtask

    task automatic test_print();
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'hC8);
        send_byte(8'h81);
        send_byte(8'h82);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] exp_tab [5];
            exp_tab = '{8'h41, 8'h42, 8'h3F, 8'h81, 8'h3F};
            @(negedge clk); rin = 4'd0; cin = 6'(i); #1;
            checks++;
            if (exp_read(0, i) != 8'h5F && charout !== exp_tab[i]) begin
                failures++;
                $display("FAIL print_cell c=%0d got=%h exp=%h", i, charout, exp_tab[i]);
            end
        end
    endtask

    task automatic test_wrap_backspace();
        send_byte(8'h0C);
        for (int i = 0; i < COLS; i++) send_byte(8'h58);
        for (int c = 0; c < COLS; c++) begin
            @(negedge clk); rin = 4'd0; cin = 6'(c); #1;
            checks++;
            if (charout !== 8'h58) begin
                failures++;
                $display("FAIL wrap_row0 c=%0d got=%h exp=58", c, charout);
            end
        end
        checks++;
        if (cursor_row !== 4'd1 || cursor_col !== 6'd0) begin
            failures++;
            $display("FAIL wrap_cursor got=(%0d,%0d) exp=(1,0)", cursor_row, cursor_col);
        end
        send_byte(8'h08);
        checks++;
        if (cursor_row !== 4'd0 || cursor_col !== 6'd19) begin
            failures++;
            $display("FAIL bs_cursor got=(%0d,%0d) exp=(0,19)", cursor_row, cursor_col);
        end
        @(negedge clk); rin = 4'd0; cin = 6'd19; #1;
        checks++;
        if (charout !== exp_read(0, 19) || m_cell[0][19] !== 8'h20) begin
            failures++;
            $display("FAIL bs_cell got=%h exp=%h", charout, exp_read(0, 19));
        end
    endtask

    task automatic test_random();
        int k;
        logic [7:0] b;
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 99);
            if (k < 6)       b = (k < 3) ? 8'h0A : 8'h0D;
            else if (k < 14) b = 8'h08;
            else if (k < 15) b = 8'h0C;
            else             b = 8'($urandom);
            send_byte(b);
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                @(negedge clk); rin = 4'(r); cin = 6'(c); #1;
                checks++;
                if (charout !== exp_read(r, c)) begin
                    failures++;
                    $display("FAIL random_screen r=%0d c=%0d got=%h exp=%h", r, c, charout, exp_read(r, c));
                end
            end
    endtask

    task automatic test_scroll();
        logic [7:0] old_row1 [COLS];
        send_byte(8'h0D);
        while (m_row < ROWS - 1) send_byte(8'h0A);
        for (int i = 0; i < COLS - 1; i++) send_byte(8'($urandom_range(33, 126)));
        old_row1 = m_cell[1];
        send_byte(8'h0A);
        for (int c = 0; c < COLS; c++) begin
            @(negedge clk); rin = 4'd0; cin = 6'(c); #1;
            checks++;
            if (exp_read(0, c) != 8'h5F && charout !== old_row1[c]) begin
                failures++;
                $display("FAIL scroll_row0 c=%0d got=%h exp=%h", c, charout, old_row1[c]);
            end
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                @(negedge clk); rin = 4'(r); cin = 6'(c); #1;
                checks++;
                if (charout !== exp_read(r, c)) begin
                    failures++;
                    $display("FAIL scroll_screen r=%0d c=%0d got=%h exp=%h", r, c, charout, exp_read(r, c));
                end
            end
    endtask

    task automatic test_reset_mid_scroll();
        int n, guard;
        logic [3:0] oor_r [4];
        logic [5:0] oor_c [4];
        send_byte(8'h0D);
        while (m_row < ROWS - 1) send_byte(8'h0A);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(33, 126)));
        @(negedge clk); char_in = 8'h0A; char_valid = 1'b1;
        guard = 0;
        while (char_ready !== 1'b1 && guard < 400) begin @(negedge clk); guard++; end
        @(posedge clk); #1; char_valid = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_scroll_busy got=%b exp=1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_blank();
        n = 0;
        while (char_ready !== 1'b1 && n < 400) begin n++; @(negedge clk); end
        checks++;
        if (n != CELLS) begin
            failures++;
            $display("FAIL abort_clear_cycles got=%0d exp=%0d", n, CELLS);
        end
        checks++;
        if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin
            failures++;
            $display("FAIL abort_cursor got=(%0d,%0d) exp=(0,0)", cursor_row, cursor_col);
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                @(negedge clk); rin = 4'(r); cin = 6'(c); #1;
                checks++;
                if (charout !== exp_read(r, c)) begin
                    failures++;
                    $display("FAIL abort_screen r=%0d c=%0d got=%h exp=%h", r, c, charout, exp_read(r, c));
                end
            end
        for (int i = 0; i < 25; i++) send_byte(8'($urandom_range(33, 126)));
        send_byte(8'h0C);
        for (int i = 0; i < 45; i++) send_byte(8'($urandom_range(33, 126)));
        oor_r = '{4'd7, 4'd0, 4'd15, 4'd6};
        oor_c = '{6'd0, 6'd20, 6'd63, 6'd20};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); rin = oor_r[i]; cin = oor_c[i]; #1;
            checks++;
            if (charout !== 8'h20) begin
                failures++;
                $display("FAIL out_of_range r=%0d c=%0d got=%h exp=20", oor_r[i], oor_c[i], charout);
            end
        end
    endtask

    task automatic test_cursor_cell();
        send_byte(8'h0D);
        send_byte(8'h08);
        send_byte(8'h08);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); rin = 4'(m_row); cin = 6'(m_col); #1;
            checks++;
            if (charout !== exp_read(m_row, m_col)) begin
                failures++;
                $display("FAIL cursor_cell cyc=%0d got=%h exp=%h", cyc, charout, exp_read(m_row, m_col));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        char_valid = 1'b0;
        char_in = '0;
        rin = '0;
        cin = '0;
        test_reset();
        test_print();
        test_wrap_backspace();
        test_random();
        test_scroll();
        test_reset_mid_scroll();
        test_cursor_cell();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
